cci_mpf_shim_rd_arb: RTL and testbench

- N-way round-robin arbiter sharing one MPF channel-0 (read) request port among N_REQ AFU-side requesters.
- Replaces each request's mdata with an internal tag and saves the original mdata plus requester index in a tag table.
- Routes each read response back to its requester with the original mdata restored.
- Sits between AFU clients and the MPF c0 Tx/Rx path.

---
 rtl/cci_mpf_if_pkg.sv | 37 +++
 rtl/cci_mpf_shim_pkg.sv | 16 +
 rtl/cci_mpf_prim_rr_arb.sv | 44 ++++
 rtl/cci_mpf_shim_rd_arb.sv | 184 ++++++++++++++++++
 tb/tb_cci_mpf_shim_rd_arb.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cci_mpf_if_pkg.sv
// Minimal CCI/MPF header types and widths used by the MPF shims.
package cci_mpf_if_pkg;

  localparam int CCI_MDATA_WIDTH  = 16;
  localparam int CCI_CLDATA_WIDTH = 512;

  typedef logic [CCI_MDATA_WIDTH-1:0] t_cci_mdata;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd;
    logic [41:0] address;
    t_cci_mdata  mdata;
  } t_cci_c0_reqmemhdr;

  typedef struct packed {
    logic [7:0]        ext_flags;
    t_cci_c0_reqmemhdr base;
  } t_cci_mpf_c0_reqmemhdr;

  localparam int CCI_MPF_TX_MEMHDR_WIDTH = $bits(t_cci_mpf_c0_reqmemhdr);

  typedef struct packed {
    logic [1:0] vc_used;
    logic       rsvd1;
    logic       hit_miss;
    logic [1:0] rsvd0;
    logic [1:0] cl_num;
    logic [3:0] resp_type;
    t_cci_mdata mdata;
  } t_cci_c0_rsphdr;

  localparam int CCI_RX_MEMHDR_WIDTH = $bits(t_cci_c0_rsphdr);

endpackage

// File: rtl/cci_mpf_shim_pkg.sv
// Shared types and defaults for the MPF shims (read-side arbiter tag table).
package cci_mpf_shim_pkg;
  import cci_mpf_if_pkg::*;

  localparam int RD_ARB_N_REQ_DEFAULT           = 4;
  localparam int RD_ARB_MAX_OUTSTANDING_DEFAULT = 64;
  localparam int RD_ARB_REQ_IDX_W               = 4;  // enough for 16 requesters

  typedef logic [$clog2(RD_ARB_MAX_OUTSTANDING_DEFAULT)-1:0] t_rd_arb_tag;

  typedef struct packed {
    t_cci_mdata                  mdata;
    logic [RD_ARB_REQ_IDX_W-1:0] idx;
  } t_rd_arb_tbl_entry;

endpackage

// File: rtl/cci_mpf_prim_rr_arb.sv
// Generic N-way round-robin picker: first request at or after the pointer wins;
// the pointer moves past the winner only when the caller consumes the pick.
module cci_mpf_prim_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] ptr;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int off = N_REQ-1; off >= 0; off--) begin
      j = (int'(ptr) + off) % N_REQ;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        any       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= (int'(grant_idx) == N_REQ-1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cci_mpf_shim_rd_arb.sv
// Round-robin read-request arbiter with mdata tagging and response routing.
// Optional per-requester counters enabled by CCI_MPF_SHIM_RD_ARB_STATS_EN.
module cci_mpf_shim_rd_arb
  import cci_mpf_if_pkg::*;
  import cci_mpf_shim_pkg::*;
#(
  parameter int N_REQ           = RD_ARB_N_REQ_DEFAULT,
  parameter int MAX_OUTSTANDING = RD_ARB_MAX_OUTSTANDING_DEFAULT
)(
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [N_REQ-1:0]                         req_valid,
  input  logic [N_REQ*CCI_MPF_TX_MEMHDR_WIDTH-1:0] req_hdr,
  output logic [N_REQ-1:0]                         req_grant,
  output t_cci_mpf_c0_reqmemhdr                    c0_tx_hdr,
  output logic                                     c0_tx_valid,
  input  logic                                     c0_tx_almfull,
  input  logic                                     c0_rx_valid,
  input  t_cci_c0_rsphdr                           c0_rx_hdr,
  input  logic [CCI_CLDATA_WIDTH-1:0]              c0_rx_data,
  output logic [N_REQ-1:0]                         rsp_valid,
  output t_cci_c0_rsphdr                           rsp_hdr,
  output logic [CCI_CLDATA_WIDTH-1:0]              rsp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
  output logic                                     err_bad_tag
`ifdef CCI_MPF_SHIM_RD_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]                      stat_grants,
  output logic [31:0]                              stat_stall_cycles
`endif
);

  localparam int TAG_W = $clog2(MAX_OUTSTANDING);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int HDR_W = CCI_MPF_TX_MEMHDR_WIDTH;

  logic [MAX_OUTSTANDING-1:0] busy;
  t_rd_arb_tbl_entry          tbl [MAX_OUTSTANDING];
  logic [TAG_W-1:0]           alloc_tag;
  logic                       have_free;
  logic [OUT_W-1:0]           out_cnt;
  logic                       err_q;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic             accept;

  t_cci_mpf_c0_reqmemhdr hdr_arr [N_REQ];
  t_cci_mpf_c0_reqmemhdr tx_hdr_nxt;

  logic              tx_vld_p1;
  t_cci_mpf_c0_reqmemhdr tx_hdr_p1;
  logic [N_REQ-1:0]  rsp_vld_p1;
  t_cci_c0_rsphdr    rsp_hdr_p1;
  logic [CCI_CLDATA_WIDTH-1:0] rsp_data_p1;

  logic [TAG_W-1:0]  rx_tag;
  logic              rx_in_range;
  logic              rx_ok;
  logic              rx_bad;
  t_rd_arb_tbl_entry rx_ent;
  t_cci_c0_rsphdr    rsp_hdr_nxt;

  // Lowest-index free tag; the reversed scan leaves the smallest index last.
  always_comb begin
    alloc_tag = '0;
    for (int t = MAX_OUTSTANDING-1; t >= 0; t--) begin
      if (!busy[t]) alloc_tag = TAG_W'(t);
    end
  end

  assign have_free = ~&busy;
  assign accept    = !reset && !c0_tx_almfull && have_free && arb_any;
  assign req_grant = accept ? arb_grant : '0;

  cci_mpf_prim_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) rr_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      hdr_arr[i] = t_cci_mpf_c0_reqmemhdr'(req_hdr[i*HDR_W +: HDR_W]);
    end
  end

  always_comb begin
    tx_hdr_nxt            = hdr_arr[arb_idx];
    tx_hdr_nxt.base.mdata = t_cci_mdata'(alloc_tag);
  end

  assign rx_tag = c0_rx_hdr.mdata[TAG_W-1:0];

  if (MAX_OUTSTANDING == (1 << TAG_W)) begin : g_pow2
    assign rx_in_range = 1'b1;
  end else begin : g_range
    assign rx_in_range = (int'(rx_tag) < MAX_OUTSTANDING);
  end

  assign rx_ok  = c0_rx_valid && rx_in_range && busy[rx_tag];
  assign rx_bad = c0_rx_valid && !rx_ok;
  assign rx_ent = tbl[rx_tag];

  always_comb begin
    rsp_hdr_nxt       = c0_rx_hdr;
    rsp_hdr_nxt.mdata = rx_ent.mdata;
  end

  // Stage p1: control side of the request/response registers and tag state.
  // An allocated tag is never the one being freed, since it was free this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      out_cnt    <= '0;
      err_q      <= 1'b0;
      tx_vld_p1  <= 1'b0;
      rsp_vld_p1 <= '0;
    end else begin
      tx_vld_p1  <= accept;
      rsp_vld_p1 <= rx_ok ? (N_REQ'(1) << rx_ent.idx) : '0;
      if (rx_bad) err_q <= 1'b1;
      if (accept) busy[alloc_tag] <= 1'b1;
      if (rx_ok)  busy[rx_tag]    <= 1'b0;
      case ({accept, rx_ok})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Stage p1: data side, qualified only by the valids above.
  always_ff @(posedge clk) begin
    if (accept) begin
      tbl[alloc_tag].mdata <= hdr_arr[arb_idx].base.mdata;
      tbl[alloc_tag].idx   <= RD_ARB_REQ_IDX_W'(arb_idx);
      tx_hdr_p1            <= tx_hdr_nxt;
    end
    rsp_hdr_p1  <= rsp_hdr_nxt;
    rsp_data_p1 <= c0_rx_data;
  end

  assign c0_tx_valid = tx_vld_p1;
  assign c0_tx_hdr   = tx_hdr_p1;
  assign rsp_valid   = rsp_vld_p1;
  assign rsp_hdr     = rsp_hdr_p1;
  assign rsp_data    = rsp_data_p1;
  assign outstanding = out_cnt;
  assign err_bad_tag = err_q;

`ifdef CCI_MPF_SHIM_RD_ARB_STATS_EN
  logic [31:0] grant_cnt [N_REQ];
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_grant[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
      if (|req_valid && !accept) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) stat_grants[i*32 +: 32] = grant_cnt[i];
  end

  assign stat_stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_cci_mpf_shim_rd_arb.sv
// Bench for cci_mpf_shim_rd_arb: queue/array reference model, directed scenarios, random soak.
`timescale 1ns/1ps
module tb_cci_mpf_shim_rd_arb;
  import cci_mpf_if_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 64;
  localparam int HW   = CCI_MPF_TX_MEMHDR_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         reset;
  logic [N-1:0]                 req_valid, req_grant, rsp_valid;
  logic [N*HW-1:0]              req_hdr;
  t_cci_mpf_c0_reqmemhdr        c0_tx_hdr;
  logic                         c0_tx_valid, c0_tx_almfull, c0_rx_valid, err_bad_tag;
  t_cci_c0_rsphdr               c0_rx_hdr, rsp_hdr;
  logic [CCI_CLDATA_WIDTH-1:0]  c0_rx_data, rsp_data;
  logic [6:0]                   outstanding;
`ifdef CCI_MPF_SHIM_RD_ARB_STATS_EN
  logic [N*32-1:0]              stat_grants;
  logic [31:0]                  stat_stall_cycles;
`endif

  cci_mpf_shim_rd_arb #(.N_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_hdr(req_hdr),
    .req_grant(req_grant), .c0_tx_hdr(c0_tx_hdr), .c0_tx_valid(c0_tx_valid),
    .c0_tx_almfull(c0_tx_almfull), .c0_rx_valid(c0_rx_valid), .c0_rx_hdr(c0_rx_hdr),
    .c0_rx_data(c0_rx_data), .rsp_valid(rsp_valid), .rsp_hdr(rsp_hdr),
    .rsp_data(rsp_data), .outstanding(outstanding), .err_bad_tag(err_bad_tag)
`ifdef CCI_MPF_SHIM_RD_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: which tags are in use, who owns them, what mdata they replaced.
  bit                    m_busy  [MAXO];
  t_cci_mdata            m_mdata [MAXO];
  int                    m_owner [MAXO];
  int                    m_ptr = 0;
  bit                    m_err = 0;
  bit                    m_tx_vld = 0;
  t_cci_mpf_c0_reqmemhdr m_tx_hdr;
  bit [N-1:0]            m_rsp_vld = '0;
  t_cci_c0_rsphdr        m_rsp_hdr;
  logic [CCI_CLDATA_WIDTH-1:0] m_rsp_data;

  bit                    pend_v [N];
  t_cci_mpf_c0_reqmemhdr pend_h [N];

  logic [N-1:0] obs_grant, obs_rsp;
  logic         obs_err;
  t_cci_mdata   obs_tx_mdata, obs_rsp_mdata;
  int           obs_out;
  int           last_g;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int nbusy();
    int n = 0;
    for (int t = 0; t < MAXO; t++) n += int'(m_busy[t]);
    return n;
  endfunction

  function automatic t_cci_mpf_c0_reqmemhdr rand_hdr();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[HW-1:0];
  endfunction

  task automatic set_rx(input bit v, input t_cci_mdata md);
    logic [31:0] r;
    r = $urandom();
    c0_rx_valid     = v;
    c0_rx_hdr       = r[CCI_RX_MEMHDR_WIDTH-1:0];
    c0_rx_hdr.mdata = md;
    for (int w = 0; w < CCI_CLDATA_WIDTH/32; w++) c0_rx_data[w*32 +: 32] = $urandom();
  endtask

  // One clock: drive requesters, compare every output against the model, advance the model.
  task automatic step();
    int g, nb, tag, rt;
    logic [N-1:0] eg;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend_v[i];
      req_hdr[i*HW +: HW]   = pend_h[i];
    end
    #1;
    nb = nbusy();
    chk("c0_tx_valid", c0_tx_valid, m_tx_vld);
    if (m_tx_vld) chk("c0_tx_hdr", c0_tx_hdr, m_tx_hdr);
    chk("rsp_valid", rsp_valid, m_rsp_vld);
    if (m_rsp_vld != '0) begin
      chk("rsp_hdr", rsp_hdr, m_rsp_hdr);
      chk("rsp_data", rsp_data, m_rsp_data);
    end
    chk("outstanding", outstanding, nb);
    chk("err_bad_tag", err_bad_tag, m_err);
    g = -1;
    if (!reset && !c0_tx_almfull && nb < MAXO)
      for (int k = 0; k < N; k++)
        if (g < 0 && pend_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    eg = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_grant", req_grant, eg);
    obs_grant     = req_grant;
    obs_rsp       = rsp_valid;
    obs_err       = err_bad_tag;
    obs_tx_mdata  = c0_tx_hdr.base.mdata;
    obs_rsp_mdata = rsp_hdr.mdata;
    obs_out       = int'(outstanding);

    if (reset) begin
      for (int t = 0; t < MAXO; t++) m_busy[t] = 1'b0;
      m_ptr = 0; m_err = 1'b0; m_tx_vld = 1'b0; m_rsp_vld = '0;
      g = -1;
    end else begin
      tag = -1;
      for (int t = 0; t < MAXO; t++) if (g >= 0 && tag < 0 && !m_busy[t]) tag = t;
      m_tx_vld  = (g >= 0);
      m_rsp_vld = '0;
      if (g >= 0) begin
        m_tx_hdr            = pend_h[g];
        m_tx_hdr.base.mdata = t_cci_mdata'(tag);
        m_ptr               = (g + 1) % N;
      end
      if (c0_rx_valid) begin
        rt = int'(c0_rx_hdr.mdata) % MAXO;
        if (m_busy[rt]) begin
          m_rsp_vld       = N'(1) << m_owner[rt];
          m_rsp_hdr       = c0_rx_hdr;
          m_rsp_hdr.mdata = m_mdata[rt];
          m_rsp_data      = c0_rx_data;
          m_busy[rt]      = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (g >= 0) begin
        m_busy[tag]  = 1'b1;
        m_mdata[tag] = pend_h[g].base.mdata;
        m_owner[tag] = g;
      end
    end
    last_g = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic after_grant(input bit renew);
    if (last_g >= 0) begin
      if (renew) pend_h[last_g] = rand_hdr();
      else       pend_v[last_g] = 1'b0;
    end
  endtask

  task automatic all_pending();
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b1;
      pend_h[i] = rand_hdr();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    c0_tx_almfull = 1'b0;
    set_rx(1'b0, '0);
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_c0_tx_valid", c0_tx_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_outstanding", outstanding, '0);
    chk("rst_err_bad_tag", err_bad_tag, 1'b0);
  endtask

  initial begin
    int q[$];
`ifdef CCI_MPF_SHIM_RD_ARB_STATS_EN
    logic [31:0] s0;
`endif
    reset = 1'b1; c0_tx_almfull = 1'b0; req_valid = '0; req_hdr = '0;
    c0_rx_valid = 1'b0; c0_rx_hdr = '0; c0_rx_data = '0;
    for (int i = 0; i < N; i++) begin pend_v[i] = 1'b0; pend_h[i] = '0; end
    @(negedge clk);
    do_reset();

    // Round-robin order with everyone requesting; tags 0,1,2,... one cycle later.
    all_pending();
    for (int k = 0; k < 9; k++) begin
      step();
      if (k < 8) chk("rr_order", obs_grant, 4'b0001 << (k % 4));
      if (k > 0) chk("rr_tag", obs_tx_mdata, 16'(k - 1));
      after_grant(1'b1);
    end

    // mdata restore: requester 2 gets tag 0, response with mdata 0 returns 0xBEEF.
    do_reset();
    pend_v[2] = 1'b1; pend_h[2] = rand_hdr(); pend_h[2].base.mdata = 16'hBEEF;
    step();
    chk("restore_grant", obs_grant, 4'b0100);
    after_grant(1'b0);
    step();
    chk("restore_tag", obs_tx_mdata, 16'h0000);
    set_rx(1'b1, 16'h0000);
    step();
    set_rx(1'b0, '0);
    step();
    chk("restore_rsp_valid", obs_rsp, 4'b0100);
    chk("restore_mdata", obs_rsp_mdata, 16'hBEEF);

    // Almost-full holds off every grant; the cycle after it drops, requester 3 wins.
    all_pending();
    c0_tx_almfull = 1'b1;
`ifdef CCI_MPF_SHIM_RD_ARB_STATS_EN
    s0 = stat_stall_cycles;
`endif
    for (int k = 0; k < 10; k++) begin
      step();
      chk("almfull_no_grant", obs_grant, 4'b0000);
    end
    c0_tx_almfull = 1'b0;
`ifdef CCI_MPF_SHIM_RD_ARB_STATS_EN
    chk("stall_cycles", stat_stall_cycles - s0, 32'd10);
`endif
    step();
    chk("almfull_resume", obs_grant, 4'b1000);
    after_grant(1'b1);

    // Full table: 64 grants, then nothing until tag 5 is returned.
    do_reset();
    all_pending();
    for (int k = 0; k < MAXO; k++) begin step(); after_grant(1'b1); end
    step();
    chk("full_outstanding", obs_out, MAXO);
    chk("full_no_grant", obs_grant, 4'b0000);
    step();
    set_rx(1'b1, 16'd5);
    step();
    chk("full_free_same_cycle", obs_grant, 4'b0000);
    set_rx(1'b0, '0);
    step();
    chk("full_regrant", obs_grant, 4'b0001);
    after_grant(1'b1);
    step();
    chk("full_reuse_tag5", obs_tx_mdata, 16'd5);

    // Grant and response together at outstanding=10: count holds, freed tag not reused.
    do_reset();
    all_pending();
    for (int k = 0; k < 10; k++) begin step(); after_grant(1'b1); end
    set_rx(1'b1, 16'd3);
    step();
    chk("simul_out_before", obs_out, 10);
    after_grant(1'b1);
    set_rx(1'b0, '0);
    step();
    chk("simul_out_after", obs_out, 10);
    chk("simul_new_tag", obs_tx_mdata, 16'd10);
    chk("simul_rsp_owner", obs_rsp, 4'b1000);
    after_grant(1'b1);

    // Response to a free tag: sticky error, no response, cleared by reset.
    do_reset();
    set_rx(1'b1, 16'd7);
    step();
    set_rx(1'b0, '0);
    step();
    chk("bad_tag_err", obs_err, 1'b1);
    chk("bad_tag_no_rsp", obs_rsp, 4'b0000);
    step();
    chk("bad_tag_sticky", obs_err, 1'b1);
    do_reset();

    // Random soak: requests come and go, responses return in random order.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      c0_tx_almfull = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
          pend_v[i] = 1'b1; pend_h[i] = rand_hdr();
        end else if (pend_v[i] && $urandom_range(0, 31) == 0) begin
          pend_v[i] = 1'b0;
        end
      end
      q.delete();
      for (int t = 0; t < MAXO; t++) if (m_busy[t]) q.push_back(t);
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        logic [15:0] r16;
        r16 = 16'($urandom());
        set_rx(1'b1, {r16[15:6], 6'(q[$urandom_range(0, q.size() - 1)])});
      end else begin
        set_rx(1'b0, '0);
      end
      step();
      after_grant(1'b0);
    end
    set_rx(1'b0, '0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
